// File: rtl/fcvt_w_s_if.sv
// fcvt_w_s_if: operand/result bundle for the float-to-integer converter.
//
// Protocol: valid-only, no ready. The producer asserts valid_input for one
// cycle per operation with a/rm/is_unsigned stable around that clock edge;
// the converter always accepts. Exactly three edges later valid_output is
// high for one cycle with y/fflags carrying that operation's result.
// Results leave in issue order. y/fflags hold their last value while
// valid_output is low.
//
// Signals:
//   valid_input  producer -> converter   operation present this cycle
//   a[31:0]      producer -> converter   IEEE-754 binary32 operand
//   rm[2:0]      producer -> converter   rounding mode (RNE/RTZ/RDN/RUP/RMM)
//   is_unsigned  producer -> converter   0 = FCVT.W.S, 1 = FCVT.WU.S
//   valid_output converter -> consumer   y/fflags hold a completed result
//   y[31:0]      converter -> consumer   integer result
//   fflags[4:0]  converter -> consumer   {NV,DZ,OF,UF,NX}
interface fcvt_w_s_if;
  logic        valid_input;
  logic [31:0] a;
  logic [2:0]  rm;
  logic        is_unsigned;
  logic        valid_output;
  logic [31:0] y;
  logic [4:0]  fflags;

  modport master (
    output valid_input, a, rm, is_unsigned,
    input  valid_output, y, fflags
  );

  modport slave (
    input  valid_input, a, rm, is_unsigned,
    output valid_output, y, fflags
  );
endinterface

// File: rtl/fcvt_w_s.sv
// fcvt_w_s: three-stage pipelined binary32 -> 32-bit integer converter
// (RISC-V FCVT.W.S / FCVT.WU.S) with all five static rounding modes and
// NV/NX flags. One operation per cycle, fixed latency of 3 edges.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; clears every stage valid and the
//        y/fflags/valid_output registers
//   bus  fcvt_w_s_if.slave: valid_input/a/rm/is_unsigned in,
//        valid_output/y/fflags out
//
// Stages:
//   S0  input register
//   S1  unpack, classify, align into integer magnitude + guard + sticky
//   S2  rounding increment, range check, saturation, sign application
//   out y/fflags register, loaded only when the S2 stage is valid
module fcvt_w_s (
  input logic      clk,
  input logic      rst,
  fcvt_w_s_if.slave bus
);

  // ---------------- S0: input register ----------------
  logic        v0;
  logic [31:0] a0;
  logic [2:0]  rm0;
  logic        u0;

  always_ff @(posedge clk) begin
    if (rst) v0 <= 1'b0;
    else     v0 <= bus.valid_input;
    a0  <= bus.a;
    rm0 <= bus.rm;
    u0  <= bus.is_unsigned;
  end

  // ---------------- S1: unpack / classify / align ----------------
  logic [7:0]  exp_c;
  logic [22:0] frac_c;
  logic        nan_c, inf_c;
  logic [4:0]  sh_c;
  logic [54:0] aligned_c;
  logic [31:0] mag_c;
  logic        g_c, st_c, ovf_c;

  assign exp_c  = a0[30:23];
  assign frac_c = a0[22:0];
  assign nan_c  = (exp_c == 8'hFF) && (frac_c != 23'd0);
  assign inf_c  = (exp_c == 8'hFF) && (frac_c == 23'd0);
  // For exponents 127..158 the unbiased exponent (E-127) equals (E+1) mod 32,
  // so the left-shift amount comes straight from the low exponent bits.
  assign sh_c      = exp_c[4:0] + 5'd1;
  // Fixed point: binary point sits between bits 23 and 22 of aligned_c.
  assign aligned_c = {31'd0, 1'b1, frac_c} << sh_c;

  always_comb begin
    mag_c = 32'd0;
    g_c   = 1'b0;
    st_c  = 1'b0;
    ovf_c = 1'b0;
    if (exp_c == 8'hFF) begin
      // NaN/Inf are carried by their own class bits.
    end else if (exp_c >= 8'd159) begin
      ovf_c = 1'b1;                    // |x| >= 2^32
    end else if (exp_c >= 8'd127) begin
      mag_c = aligned_c[54:23];
      g_c   = aligned_c[22];
      st_c  = |aligned_c[21:0];
    end else if (exp_c == 8'd126) begin
      g_c  = 1'b1;                     // 0.5 <= |x| < 1
      st_c = |frac_c;
    end else begin
      // |x| < 0.5 or subnormal: only a non-zero operand leaves a sticky bit.
      st_c = (exp_c != 8'd0) || (frac_c != 23'd0);
    end
  end

  logic        v1, s1, g1, st1, u1, nan1, inf1, ovf1;
  logic [31:0] mag1;
  logic [2:0]  rm1;

  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else     v1 <= v0;
    mag1 <= mag_c;
    g1   <= g_c;
    st1  <= st_c;
    s1   <= a0[31];
    rm1  <= rm0;
    u1   <= u0;
    nan1 <= nan_c;
    inf1 <= inf_c;
    ovf1 <= ovf_c;
  end

  // ---------------- S2: round / range check / sign ----------------
  logic        inc_c;
  logic [32:0] rmag_c;
  logic        in_range_c, invalid_c;
  logic [31:0] y_c;
  logic [4:0]  f_c;

  always_comb begin
    inc_c = 1'b0;
    case (rm1)
      3'b001:  inc_c = 1'b0;                      // RTZ
      3'b010:  inc_c = s1 & (g1 | st1);           // RDN
      3'b011:  inc_c = ~s1 & (g1 | st1);          // RUP
      3'b100:  inc_c = g1;                        // RMM
      default: inc_c = g1 & (st1 | mag1[0]);      // RNE (and 101-111)
    endcase
  end

  // 33 bits so that a carry out of 0xFFFFFFFF is caught by the range check.
  assign rmag_c = {1'b0, mag1} + {32'd0, inc_c};

  always_comb begin
    in_range_c = 1'b0;
    if (u1)
      // A result that rounds to zero is representable whatever the sign.
      in_range_c = (~s1 & ~rmag_c[32]) | (rmag_c == 33'd0);
    else if (s1)
      in_range_c = (rmag_c <= 33'h0_8000_0000);
    else
      in_range_c = (rmag_c <= 33'h0_7FFF_FFFF);
  end

  assign invalid_c = nan1 | inf1 | ovf1 | ~in_range_c;

  always_comb begin
    y_c = 32'd0;
    f_c = 5'd0;
    if (invalid_c) begin
      f_c = 5'b10000;
      // NaN saturates toward the positive limit regardless of its sign bit.
      if (u1) y_c = (nan1 | ~s1) ? 32'hFFFF_FFFF : 32'h0000_0000;
      else    y_c = (nan1 | ~s1) ? 32'h7FFF_FFFF : 32'h8000_0000;
    end else begin
      y_c = s1 ? (~rmag_c[31:0] + 32'd1) : rmag_c[31:0];
      f_c = {4'b0000, g1 | st1};
    end
  end

  logic        v2;
  logic [31:0] y2;
  logic [4:0]  f2;

  always_ff @(posedge clk) begin
    if (rst) v2 <= 1'b0;
    else     v2 <= v1;
    y2 <= y_c;
    f2 <= f_c;
  end

  // ---------------- output register ----------------
  logic        vo_q;
  logic [31:0] y_q;
  logic [4:0]  f_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vo_q <= 1'b0;
      y_q  <= 32'd0;
      f_q  <= 5'd0;
    end else begin
      vo_q <= v2;
      if (v2) begin
        y_q <= y2;
        f_q <= f2;
      end
    end
  end

  assign bus.valid_output = vo_q;
  assign bus.y            = y_q;
  assign bus.fflags       = f_q;

endmodule

// File: tb/tb_fcvt_w_s.sv
// tb_fcvt_w_s: self-checking bench for fcvt_w_s. Directed vectors for the
// rounding, boundary, special-value and unsigned-negative cases, random
// operands checked against an arithmetic reference model, a streamed
// pipeline test with bubbles, and a reset-while-busy test.
module tb_fcvt_w_s;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fcvt_w_s_if bus ();

  fcvt_w_s dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q  [$];
  logic [4:0]  expf_q [$];

  typedef struct packed {
    logic [31:0] a;
    logic [2:0]  rm;
    logic        u;
    logic [31:0] y;
    logic [4:0]  f;
  } vec_t;

  // ---------------- reference model ----------------
  // Works on the exact value |x| = m * 2^k: integer part plus a comparison
  // of the remainder against one half, then rounds the signed value and
  // range-checks it as a plain 64-bit integer.
  function automatic void model(input logic [31:0] av, input logic [2:0] r,
                                input logic u, output logic [31:0] ey,
                                output logic [4:0] ef);
    bit     s, nan, inf, huge, inexact, gt, eq, up, ok;
    int     e_b, k, d, mode;
    longint m, ip, rem, half, mag, res;
    s   = av[31];
    e_b = int'(av[30:23]);
    m   = longint'(av[22:0]);
    nan = (e_b == 255) && (m != 0);
    inf = (e_b == 255) && (m == 0);
    huge = 0; ip = 0; inexact = 0; gt = 0; eq = 0;
    if (e_b != 0) m = m + 64'sd8388608;
    k = ((e_b == 0) ? 1 : e_b) - 150;
    if (!nan && !inf) begin
      if (k >= 0) begin
        if (k > 38) huge = 1;
        else        ip = m << k;
      end else begin
        d = -k;
        if (d >= 25) begin
          inexact = (m != 0);              // |x| < 0.5
        end else begin
          ip      = m >> d;
          rem     = m - (ip << d);
          half    = 64'sd1 << (d - 1);
          inexact = (rem != 0);
          gt      = (rem > half);
          eq      = (rem == half);
        end
      end
    end
    mode = (r > 3'd4) ? 0 : int'(r);
    case (mode)
      0:       up = gt || (eq && ip[0]);
      1:       up = 0;
      2:       up = s && inexact;
      3:       up = !s && inexact;
      default: up = gt || eq;
    endcase
    mag = ip + (up ? 64'sd1 : 64'sd0);
    res = s ? -mag : mag;
    if (u) ok = (res >= 0) && (res <= 64'sd4294967295);
    else   ok = (res >= -64'sd2147483648) && (res <= 64'sd2147483647);
    ok = ok && !nan && !inf && !huge;
    if (ok) begin
      ey = res[31:0];
      ef = {4'b0000, inexact};
    end else begin
      ef = 5'b10000;
      if (u) ey = (nan || !s) ? 32'hFFFF_FFFF : 32'h0000_0000;
      else   ey = (nan || !s) ? 32'h7FFF_FFFF : 32'h8000_0000;
    end
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    logic [22:0] fr;
    fr = 23'($urandom);
    if ($urandom_range(0, 3) == 0) fr = fr & 23'h7F0000;   // favour ties
    case ($urandom_range(0, 9))
      0: v = $urandom;
      1: begin
        case ($urandom_range(0, 5))
          0: v = 32'h7FC0_0000;
          1: v = 32'hFF80_0000;
          2: v = 32'h7F80_0000;
          3: v = 32'h8000_0000;
          4: v = 32'h0000_0000;
          default: v = {1'($urandom_range(0, 1)), 8'd0, fr};
        endcase
      end
      2: v = {1'($urandom_range(0, 1)), 8'($urandom_range(156, 160)), fr};
      default: v = {1'($urandom_range(0, 1)), 8'($urandom_range(118, 160)), fr};
    endcase
    return v;
  endfunction

  // ---------------- driver ----------------
  // Issues one operation alone and samples the outputs just after the
  // third edge following the sampling edge.
  task automatic run_op(input logic [31:0] av, input logic [2:0] r,
                        input logic u, output logic [31:0] yo,
                        output logic [4:0] fo, output logic vo);
    @(negedge clk);
    bus.valid_input = 1'b1;
    bus.a           = av;
    bus.rm          = r;
    bus.is_unsigned = u;
    @(negedge clk);
    bus.valid_input = 1'b0;
    bus.a           = $urandom;
    repeat (3) @(posedge clk);
    #1;
    yo = bus.y;
    fo = bus.fflags;
    vo = bus.valid_output;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.valid_input = 1'b1;
    bus.a = 32'h4020_0000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.valid_output !== 1'b0 || bus.y !== 32'd0 || bus.fflags !== 5'd0) begin
      failures++;
      $display("FAIL reset_state got vo=%b y=%h fflags=%h want vo=0 y=0 fflags=0",
               bus.valid_output, bus.y, bus.fflags);
    end
    @(negedge clk);
    bus.valid_input = 1'b0;
    rst = 1'b0;
  endtask

  task automatic run_table(input string tag, input vec_t t[]);
    logic [31:0] yo;
    logic [4:0]  fo;
    logic        vo;
    foreach (t[i]) begin
      run_op(t[i].a, t[i].rm, t[i].u, yo, fo, vo);
      checks++;
      if (vo !== 1'b1 || yo !== t[i].y || fo !== t[i].f) begin
        failures++;
        $display("FAIL %s[%0d] a=%h rm=%0d u=%b got vo=%b y=%h fflags=%h want vo=1 y=%h fflags=%h",
                 tag, i, t[i].a, t[i].rm, t[i].u, vo, yo, fo, t[i].y, t[i].f);
      end
    end
  endtask

  task automatic test_rounding();
    vec_t t[] = new[10];
    logic [31:0] pos_y [5] = '{32'd2, 32'd2, 32'd2, 32'd3, 32'd3};
    logic [31:0] neg_y [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                               32'hFFFF_FFFE, 32'hFFFF_FFFD};
    for (int i = 0; i < 5; i++) begin
      t[i]     = '{32'h4020_0000, 3'(i), 1'b0, pos_y[i], 5'h01};
      t[i + 5] = '{32'hC020_0000, 3'(i), 1'b0, neg_y[i], 5'h01};
    end
    run_table("rounding", t);
  endtask

  task automatic test_boundaries();
    vec_t t[] = new[6];
    t[0] = '{32'hCF00_0000, 3'd0, 1'b0, 32'h8000_0000, 5'h00};
    t[1] = '{32'h4F00_0000, 3'd0, 1'b0, 32'h7FFF_FFFF, 5'h10};
    t[2] = '{32'h4F00_0000, 3'd0, 1'b1, 32'h8000_0000, 5'h00};
    t[3] = '{32'h4F80_0000, 3'd0, 1'b1, 32'hFFFF_FFFF, 5'h10};
    t[4] = '{32'h4EFF_FFFF, 3'd1, 1'b0, 32'h7FFF_FF80, 5'h00};
    t[5] = '{32'h4F7F_FFFF, 3'd3, 1'b1, 32'hFFFF_FF00, 5'h00};
    run_table("boundary", t);
  endtask

  task automatic test_specials();
    vec_t t[] = new[7];
    t[0] = '{32'h7FC0_0000, 3'd0, 1'b0, 32'h7FFF_FFFF, 5'h10};
    t[1] = '{32'h7FC0_0000, 3'd0, 1'b1, 32'hFFFF_FFFF, 5'h10};
    t[2] = '{32'hFF80_0000, 3'd0, 1'b0, 32'h8000_0000, 5'h10};
    t[3] = '{32'hFF80_0000, 3'd0, 1'b1, 32'h0000_0000, 5'h10};
    t[4] = '{32'h8000_0000, 3'd0, 1'b0, 32'h0000_0000, 5'h00};
    t[5] = '{32'h0000_0001, 3'd3, 1'b0, 32'h0000_0001, 5'h01};
    t[6] = '{32'h3F00_0000, 3'd7, 1'b0, 32'h0000_0000, 5'h01};
    run_table("special", t);
  endtask

  task automatic test_unsigned_neg();
    vec_t t[] = new[3];
    t[0] = '{32'hBE80_0000, 3'd1, 1'b1, 32'h0000_0000, 5'h01};
    t[1] = '{32'hBE80_0000, 3'd2, 1'b1, 32'h0000_0000, 5'h10};
    t[2] = '{32'hBF80_0000, 3'd0, 1'b1, 32'h0000_0000, 5'h10};
    run_table("unsigned_neg", t);
  endtask

  task automatic test_random(input int n);
    logic [31:0] av, yo, ey;
    logic [4:0]  fo, ef;
    logic [2:0]  r;
    logic        u, vo;
    for (int i = 0; i < n; i++) begin
      av = rand_operand();
      r  = 3'($urandom_range(0, 7));
      u  = 1'($urandom_range(0, 1));
      model(av, r, u, ey, ef);
      run_op(av, r, u, yo, fo, vo);
      checks++;
      if (vo !== 1'b1 || yo !== ey || fo !== ef) begin
        failures++;
        $display("FAIL random[%0d] a=%h rm=%0d u=%b got vo=%b y=%h fflags=%h want vo=1 y=%h fflags=%h",
                 i, av, r, u, vo, yo, fo, ey, ef);
      end
    end
  endtask

  task automatic test_back_to_back(input int n_ops);
    bit          in_v [$];
    int          issued = 0;
    int          cyc = 0;
    bit          have_last = 0;
    bit          bubbled = 0;
    bit          v, exp_vo;
    logic [31:0] last_y, ey, av;
    logic [4:0]  last_f, ef;
    logic [2:0]  r;
    logic        u;
    exp_q.delete();
    expf_q.delete();
    while ((issued < n_ops || exp_q.size() != 0) && cyc < 400) begin
      @(negedge clk);
      v = (issued < n_ops) && !(issued == n_ops / 2 && !bubbled) &&
          ($urandom_range(0, 2) != 0);
      av = rand_operand();
      r  = 3'($urandom_range(0, 7));
      u  = 1'($urandom_range(0, 1));
      bus.valid_input = v;
      bus.a           = av;
      bus.rm          = r;
      bus.is_unsigned = u;
      if (v) begin
        model(av, r, u, ey, ef);
        exp_q.push_back(ey);
        expf_q.push_back(ef);
        issued++;
      end else if (issued < n_ops) begin
        bubbled = 1;
      end
      in_v.push_back(v);
      @(posedge clk);
      #1;
      exp_vo = (cyc >= 3) ? in_v[cyc - 3] : 1'b0;
      checks++;
      if (bus.valid_output !== exp_vo) begin
        failures++;
        $display("FAIL b2b_valid cyc=%0d got vo=%b want vo=%b", cyc, bus.valid_output, exp_vo);
      end
      if (exp_vo && exp_q.size() != 0) begin
        ey = exp_q.pop_front();
        ef = expf_q.pop_front();
        checks++;
        if (bus.y !== ey || bus.fflags !== ef) begin
          failures++;
          $display("FAIL b2b_data cyc=%0d got y=%h fflags=%h want y=%h fflags=%h",
                   cyc, bus.y, bus.fflags, ey, ef);
        end
        last_y = ey;
        last_f = ef;
        have_last = 1;
      end else if (!exp_vo && have_last) begin
        checks++;
        if (bus.y !== last_y || bus.fflags !== last_f) begin
          failures++;
          $display("FAIL b2b_hold cyc=%0d got y=%h fflags=%h want y=%h fflags=%h",
                   cyc, bus.y, bus.fflags, last_y, last_f);
        end
      end
      cyc++;
    end
    bus.valid_input = 1'b0;
    checks++;
    if (issued < n_ops || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_timeout issued=%0d pending=%0d want issued=%0d pending=0",
               issued, exp_q.size(), n_ops);
    end
  endtask

  task automatic test_reset_flush();
    bit exp_vo;
    // Three operations in flight, then reset with another valid input held.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.valid_input = 1'b1;
      bus.a           = 32'h4120_0000 + 32'(i << 20);
      bus.rm          = 3'd0;
      bus.is_unsigned = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    bus.a = 32'hC2C8_0000;
    @(posedge clk);
    #1;
    checks++;
    if (bus.valid_output !== 1'b0 || bus.y !== 32'd0 || bus.fflags !== 5'd0) begin
      failures++;
      $display("FAIL flush_clear got vo=%b y=%h fflags=%h want vo=0 y=0 fflags=0",
               bus.valid_output, bus.y, bus.fflags);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.valid_input = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.valid_output !== 1'b0) begin
      failures++;
      $display("FAIL flush_discard got vo=%b want vo=0", bus.valid_output);
    end
    @(negedge clk);
    bus.valid_input = 1'b1;
    bus.a           = 32'h4040_0000;   // 3.0
    bus.rm          = 3'd0;
    bus.is_unsigned = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      exp_vo = (c == 3);
      checks++;
      if (bus.valid_output !== exp_vo) begin
        failures++;
        $display("FAIL flush_restart_valid c=%0d got vo=%b want vo=%b", c, bus.valid_output, exp_vo);
      end
      @(negedge clk);
      bus.valid_input = 1'b0;
    end
    checks++;
    if (bus.y !== 32'd3 || bus.fflags !== 5'd0) begin
      failures++;
      $display("FAIL flush_restart_data got y=%h fflags=%h want y=00000003 fflags=00",
               bus.y, bus.fflags);
    end
  endtask

  initial begin
    bus.valid_input = 1'b0;
    bus.a           = 32'd0;
    bus.rm          = 3'd0;
    bus.is_unsigned = 1'b0;
    rst             = 1'b1;
    test_reset();
    test_rounding();
    test_boundaries();
    test_specials();
    test_unsigned_neg();
    test_random(300);
    test_back_to_back(10);
    test_back_to_back(40);
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fcvt_w_s.md
# fcvt_w_s

Three-stage pipelined single-precision float to 32-bit integer converter implementing RISC-V FCVT.W.S and FCVT.WU.S. It is the inverse of the integer-to-float converter and sits beside it in the F-extension execute pipeline. It honours all five static rounding modes and reports NV/NX exception flags. It accepts one operation per cycle with fixed latency and no backpressure.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- valid_input  in  1  operation present on a/rm/is_unsigned this cycle
- a  in  32  IEEE-754 binary32 operand
- rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 treated as RNE (DYN is resolved and illegal values trapped upstream)
- is_unsigned  in  1  0 = FCVT.W.S (signed result), 1 = FCVT.WU.S (unsigned result)
- valid_output  out  1  y/fflags hold a completed result
- y  out  32  integer result
- fflags  out  5  {NV,DZ,OF,UF,NX}; DZ/OF/UF are always 0

## Operation
- **S0 (input register):**
  - Captures a, rm, is_unsigned and valid_input.
- **S1 (unpack, classify, align):**
  - Fields: sign s, exp E, frac f. Unbiased e = E−127.
  - NaN: E=255, f≠0. Inf: E=255, f=0. Zero: E=0, f=0.
  - Subnormal or e ≤ −2: integer part 0, guard 0, sticky 1 (sticky 0 for zero).
  - e = −1: integer part 0, guard 1, sticky = |f.
  - 0 ≤ e ≤ 31: shift {1,f} left or right into integer magnitude, guard bit and sticky OR of the remaining bits.
  - e ≥ 32: overflow flag.
  - Registers magnitude (32b), guard, sticky, s, rm, is_unsigned, class bits and overflow.
- **S2 (round, range check, sign apply):**
  - Round-up increment per mode:
    - RNE: g&(st|lsb)
    - RTZ: 0
    - RDN: s&(g|st)
    - RUP: ~s&(g|st)
    - RMM: g
  - Magnitude after the increment is 33b to catch carry-out.
- **Range rules:**
  - Signed: valid if magnitude ≤ 0x7FFFFFFF (s=0) or ≤ 0x80000000 (s=1).
  - Unsigned: valid if s=0 and magnitude ≤ 0xFFFFFFFF, or rounded magnitude = 0 (covers any sign).
- **Invalid cases:** NaN, Inf, overflow, or out of range.
  - Result: NV=1, NX=0.
  - Saturated y:
    - Signed: NaN or positive → 0x7FFFFFFF; negative → 0x80000000.
    - Unsigned: NaN or positive → 0xFFFFFFFF; negative → 0x00000000.
- **Valid cases:**
  - y = s ? −magnitude : magnitude (two's complement, 32b).
  - NX = g|st.
  - ±0.0 gives 0 with no flags.
- y and fflags update only when stage-2 valid is 1; otherwise they hold their previous value.

## Timing
- Latency is 3 cycles. Operands sampled at edge k appear on y/fflags, with valid_output=1, after edge k+3.
- Throughput is 1 per cycle. Back-to-back inputs produce back-to-back outputs in order.
- No stall and no flush input. Bubbles (valid_input=0) propagate as valid_output=0.
- Reset:
  - While rst=1 at a clock edge, all stage valids, valid_output, y and fflags clear to 0.
  - In-flight operations are discarded. No output ever appears for inputs sampled while rst=1.
  - The first valid_input sampled with rst=0 emerges 3 edges later.
- The comparison logic, the 33b incrementer and the 32b negation all sit in S2. Shifting sits in S1.

## Test plan
- **2.5 rounding (a=0x40200000, signed):**
  - RNE → y=2, NX
  - RTZ → 2
  - RDN → 2
  - RUP → 3
  - RMM → 3
  - NX set for every mode.
- **−2.5 rounding (a=0xC0200000, signed):**
  - RNE → 0xFFFFFFFE
  - RDN → 0xFFFFFFFD
  - RUP → 0xFFFFFFFE
  - RMM → 0xFFFFFFFD
  - fflags=0x01 for every mode.
- **Boundaries:**
  - 0xCF000000 signed → 0x80000000, fflags=0.
  - 0x4F000000 signed → 0x7FFFFFFF, fflags=0x10.
  - 0x4F000000 unsigned → 0x80000000, fflags=0.
  - 0x4F800000 unsigned → 0xFFFFFFFF, NV.
- **Specials:**
  - NaN 0x7FC00000 → signed 0x7FFFFFFF / unsigned 0xFFFFFFFF, NV.
  - −Inf 0xFF800000 → signed 0x80000000 / unsigned 0, NV.
  - −0.0 → 0, no flags.
  - Subnormal 0x00000001 with RUP → 1, NX.
- **Unsigned negatives:**
  - −0.25 (0xBE800000) RTZ → 0, NX only.
  - Same operand with RDN → 0, NV only.
  - −1.0 unsigned → 0, NV.
- **Pipeline:**
  - Stream 10 back-to-back operations with random bubbles; outputs arrive in order exactly 3 cycles after each input, and y/fflags hold during bubbles.
  - Assert rst for 1 cycle with 3 operations in flight → none emerge, all outputs read 0 on the next cycle, and a new input 1 cycle later emerges after 3 edges.
